// File: rtl/mc_datapath_param_pkg.sv
`default_nettype none
// ============================================================================
// Module : mc_dp_pkg
// Brief  : Shared encodings and helpers for the parametrised multi-cycle datapath.
// Rev    : 1.0
// ============================================================================
package mc_dp_pkg;

    localparam logic [2:0] c_alu_and  = 3'b000;
    localparam logic [2:0] c_alu_or   = 3'b001;
    localparam logic [2:0] c_alu_add  = 3'b010;
    localparam logic [2:0] c_alu_sltu = 3'b011;
    localparam logic [2:0] c_alu_xor  = 3'b100;
    localparam logic [2:0] c_alu_nor  = 3'b101;
    localparam logic [2:0] c_alu_sub  = 3'b110;
    localparam logic [2:0] c_alu_slt  = 3'b111;

    localparam logic [1:0] c_srcb_b     = 2'b00;
    localparam logic [1:0] c_srcb_four  = 2'b01;
    localparam logic [1:0] c_srcb_imm   = 2'b10;
    localparam logic [1:0] c_srcb_immsh = 2'b11;

    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jump   = 2'b10;
    localparam logic [1:0] c_pcsrc_jr     = 2'b11;

    // Low 28 bits of a jump target; the caller prepends PC[WIDTH-1:28].
    function automatic logic [27:0] jump_offset(input logic [25:0] instr_index);
        return {instr_index, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_datapath_param_if.sv
`default_nettype none
// ============================================================================
// Module : mc_datapath_param_if
// Brief  : Controller/memory-facing signal bundle of the multi-cycle datapath.
// Rev    : 1.0
// ============================================================================
interface mc_datapath_param_if #(
    parameter int WIDTH = 32
);
    logic             pcen;
    logic             irwrite;
    logic             regwrite;
    logic             alusrca;
    logic             iord;
    logic             memtoreg;
    logic             regdst;
    logic [1:0]       alusrcb;
    logic [1:0]       pcsrc;
    logic [2:0]       alucontrol;
    logic             mem_ready;
    logic [WIDTH-1:0] readdata;
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic [WIDTH-1:0] adr;
    logic [WIDTH-1:0] writedata;

    modport master (
        output pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
               alusrcb, pcsrc, alucontrol, mem_ready, readdata,
        input  op, funct, zero, adr, writedata
    );

    modport slave (
        input  pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
               alusrcb, pcsrc, alucontrol, mem_ready, readdata,
        output op, funct, zero, adr, writedata
    );
endinterface
`default_nettype wire

// File: rtl/mc_datapath_param_alu.sv
`default_nettype none
// ============================================================================
// Module : mc_alu
// Brief  : WIDTH-generic combinational ALU with zero flag.
// Rev    : 1.0
// ============================================================================
module mc_alu
    import mc_dp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_ctrl,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero
);

    always_comb begin
        o_result = '0;
        case (i_ctrl)
            c_alu_and:  o_result = i_a & i_b;
            c_alu_or:   o_result = i_a | i_b;
            c_alu_add:  o_result = i_a + i_b;
            c_alu_sub:  o_result = i_a - i_b;
            c_alu_xor:  o_result = i_a ^ i_b;
            c_alu_nor:  o_result = ~(i_a | i_b);
            c_alu_slt:  o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            c_alu_sltu: o_result = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
            default:    o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule
`default_nettype wire

// File: rtl/mc_datapath_param.sv
`default_nettype none
// ============================================================================
// Module : mc_datapath_param
// Brief  : Parametrised multi-cycle MIPS datapath with memory-ready stall.
// Rev    : 1.0
// ============================================================================
module mc_datapath_param
    import mc_dp_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               NREGS    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input logic                clk,
    input logic                reset,
    mc_datapath_param_if.slave bus
);

    localparam int               c_idxw  = $clog2(NREGS);
    localparam logic [5:0]       c_nregs = 6'(NREGS);
    localparam logic [WIDTH-1:0] c_four  = WIDTH'(4);

    logic [WIDTH-1:0] r_pc, r_mdr, r_a, r_b, r_aluout;
    logic [31:0]      r_ir;
    logic [WIDTH-1:0] r_rf [NREGS];

    logic [4:0]       w_rs, w_rt, w_dest;
    logic [WIDTH-1:0] w_rd1, w_rd2, w_wd;
    logic [WIDTH-1:0] w_signimm, w_signimm_sh, w_jta;
    logic [WIDTH-1:0] w_srca, w_srcb, w_aluresult, w_pcnext;
    logic             w_we;

    assign w_rs   = r_ir[25:21];
    assign w_rt   = r_ir[20:16];
    assign w_dest = bus.regdst ? r_ir[15:11] : r_ir[20:16];
    assign w_wd   = bus.memtoreg ? r_mdr : r_aluout;

    // r0 and indices beyond the implemented file read as zero.
    assign w_rd1 = (w_rs != 5'd0 && {1'b0, w_rs} < c_nregs) ? r_rf[w_rs[c_idxw-1:0]] : '0;
    assign w_rd2 = (w_rt != 5'd0 && {1'b0, w_rt} < c_nregs) ? r_rf[w_rt[c_idxw-1:0]] : '0;
    assign w_we  = bus.regwrite && (w_dest != 5'd0) && ({1'b0, w_dest} < c_nregs);

    assign w_signimm    = {{(WIDTH-16){r_ir[15]}}, r_ir[15:0]};
    assign w_signimm_sh = {w_signimm[WIDTH-3:0], 2'b00};
    assign w_jta        = {r_pc[WIDTH-1:28], jump_offset(r_ir[25:0])};

    assign w_srca = bus.alusrca ? r_a : r_pc;

    always_comb begin
        w_srcb = r_b;
        case (bus.alusrcb)
            c_srcb_b:     w_srcb = r_b;
            c_srcb_four:  w_srcb = c_four;
            c_srcb_imm:   w_srcb = w_signimm;
            c_srcb_immsh: w_srcb = w_signimm_sh;
            default:      w_srcb = r_b;
        endcase
    end

    always_comb begin
        w_pcnext = w_aluresult;
        case (bus.pcsrc)
            c_pcsrc_alu:    w_pcnext = w_aluresult;
            c_pcsrc_aluout: w_pcnext = r_aluout;
            c_pcsrc_jump:   w_pcnext = w_jta;
            c_pcsrc_jr:     w_pcnext = r_a;
            default:        w_pcnext = w_aluresult;
        endcase
    end

    mc_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_a      (w_srca),
        .i_b      (w_srcb),
        .i_ctrl   (bus.alucontrol),
        .o_result (w_aluresult),
        .o_zero   (bus.zero)
    );

    // Every architectural register, including the file, freezes while memory stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_mdr    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
            for (int i = 0; i < NREGS; i++) begin
                r_rf[i] <= '0;
            end
        end else if (bus.mem_ready) begin
            r_mdr    <= bus.readdata;
            r_a      <= w_rd1;
            r_b      <= w_rd2;
            r_aluout <= w_aluresult;
            if (bus.irwrite) begin
                r_ir <= bus.readdata[31:0];
            end
            if (bus.pcen) begin
                r_pc <= w_pcnext;
            end
            if (w_we) begin
                r_rf[w_dest[c_idxw-1:0]] <= w_wd;
            end
        end
    end

    assign bus.op        = r_ir[31:26];
    assign bus.funct     = r_ir[5:0];
    assign bus.adr       = bus.iord ? r_aluout : r_pc;
    assign bus.writedata = r_b;

endmodule
`default_nettype wire

// File: tb/tb_mc_datapath_param.sv
`default_nettype none
// ============================================================================
// Module : tb_mc_datapath_param
// Brief  : Directed self-checking bench; a 32-bit and a 64-bit/16-register
//          instance share one stimulus stream.
// Rev    : 1.0
// ============================================================================
module tb_mc_datapath_param;
    import mc_dp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst, mem_ready;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;
    logic [63:0] rd;

    int checks = 0;
    int errors = 0;

    mc_datapath_param_if #(.WIDTH(32)) bus32 ();
    mc_datapath_param_if #(.WIDTH(64)) bus64 ();

    assign bus32.pcen = pcen;           assign bus64.pcen = pcen;
    assign bus32.irwrite = irwrite;     assign bus64.irwrite = irwrite;
    assign bus32.regwrite = regwrite;   assign bus64.regwrite = regwrite;
    assign bus32.alusrca = alusrca;     assign bus64.alusrca = alusrca;
    assign bus32.iord = iord;           assign bus64.iord = iord;
    assign bus32.memtoreg = memtoreg;   assign bus64.memtoreg = memtoreg;
    assign bus32.regdst = regdst;       assign bus64.regdst = regdst;
    assign bus32.alusrcb = alusrcb;     assign bus64.alusrcb = alusrcb;
    assign bus32.pcsrc = pcsrc;         assign bus64.pcsrc = pcsrc;
    assign bus32.alucontrol = alucontrol; assign bus64.alucontrol = alucontrol;
    assign bus32.mem_ready = mem_ready; assign bus64.mem_ready = mem_ready;
    assign bus32.readdata = rd[31:0];   assign bus64.readdata = rd;

    mc_datapath_param #(
        .WIDTH    (32),
        .NREGS    (32),
        .RESET_PC (32'h0000_0100)
    ) u32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32)
    );

    mc_datapath_param #(
        .WIDTH    (64),
        .NREGS    (16),
        .RESET_PC (64'h0)
    ) u64 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus64)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_ir(input logic [31:0] instr);
        rd      = {32'h0, instr};
        irwrite = 1'b1;
        step();
        irwrite = 1'b0;
    endtask

    // IR with rt=k, MDR=v, then one write edge; B still shows the old value afterwards.
    task automatic write_reg(input logic [4:0] k, input logic [63:0] v);
        load_ir({11'b0, k, 16'h0});
        rd = v;
        step();
        memtoreg = 1'b1;
        regwrite = 1'b1;
        step();
        regwrite = 1'b0;
        memtoreg = 1'b0;
    endtask

    logic [2:0]  alu_ops [8];
    logic [31:0] alu_exp [8];

    initial begin
        alu_ops = '{c_alu_slt, c_alu_sltu, c_alu_add, c_alu_nor,
                    c_alu_xor, c_alu_sub, c_alu_and, c_alu_or};
        alu_exp = '{32'h1, 32'h0, 32'h0, 32'h0,
                    32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFF};

        reset = 1'b1; pcen = 0; irwrite = 0; regwrite = 0; alusrca = 0; iord = 0;
        memtoreg = 0; regdst = 0; mem_ready = 1; alusrcb = 2'b00; pcsrc = 2'b00;
        alucontrol = c_alu_add; rd = '0;
        step();
        step();
        check("reset_adr32", 64'(bus32.adr), 64'h100);
        check("reset_wd32", 64'(bus32.writedata), 64'h0);
        check("reset_op32", 64'(bus32.op), 64'h0);
        check("reset_funct32", 64'(bus32.funct), 64'h0);
        check("reset_adr64", bus64.adr, 64'h0);
        reset = 1'b0;

        // PC + 4
        pcen = 1; alusrcb = c_srcb_four; pcsrc = c_pcsrc_alu;
        step();
        pcen = 0; alusrcb = c_srcb_b;
        #1 check("pc_inc", 64'(bus32.adr), 64'h104);

        load_ir(32'h8C0A_0004);
        check("fetch_op", 64'(bus32.op), 64'h23);
        check("fetch_funct", 64'(bus32.funct), 64'h04);

        // lw address: r1 = 0x200, offset 4
        write_reg(5'd1, 64'h200);
        step();
        check("r1_readback", 64'(bus32.writedata), 64'h200);
        load_ir(32'h8C2A_0004);
        alusrca = 1; alusrcb = c_srcb_imm;
        step();
        step();
        iord = 1;
        #1 check("lw_aluout", 64'(bus32.adr), 64'h204);
        iord = 0; alusrca = 0; alusrcb = c_srcb_b;

        // three-cycle stall during a fetch
        mem_ready = 0; pcen = 1; irwrite = 1; alusrcb = c_srcb_four; rd = 64'h012A_4020;
        step(); step(); step();
        check("stall_pc", 64'(bus32.adr), 64'h104);
        check("stall_op", 64'(bus32.op), 64'h23);
        mem_ready = 1;
        step();
        pcen = 0; irwrite = 0; alusrcb = c_srcb_b;
        #1 check("resume_pc", 64'(bus32.adr), 64'h108);
        check("resume_funct", 64'(bus32.funct), 64'h20);
        step();
        check("resume_once", 64'(bus32.adr), 64'h108);

        write_reg(5'd0, 64'h55);
        step();
        check("r0_zero", 64'(bus32.writedata), 64'h0);

        write_reg(5'd5, 64'h55);
        check("r5_old", 64'(bus32.writedata), 64'h0);
        step();
        check("r5_new", 64'(bus32.writedata), 64'h55);

        // ALU sweep: A = r2 = 0xFFFFFFFF, B = r3 = 1
        write_reg(5'd2, 64'hFFFF_FFFF);
        write_reg(5'd3, 64'h1);
        load_ir(32'h0043_0000);
        step();
        alusrca = 1; alusrcb = c_srcb_b;
        for (int i = 0; i < 8; i++) begin
            alucontrol = alu_ops[i];
            #1 check($sformatf("zero_op%0d", alu_ops[i]), 64'(bus32.zero),
                     64'(alu_exp[i] == 32'h0));
            step();
            iord = 1;
            #1 check($sformatf("alu_op%0d", alu_ops[i]), 64'(bus32.adr), 64'(alu_exp[i]));
            iord = 0;
        end
        alusrca = 0; alucontrol = c_alu_add;

        // jr, then jr to a high page followed by j
        write_reg(5'd4, 64'h4000);
        load_ir(32'h0080_0000);
        step();
        pcsrc = c_pcsrc_jr; pcen = 1;
        step();
        pcen = 0; pcsrc = c_pcsrc_alu;
        #1 check("jr_pc", 64'(bus32.adr), 64'h4000);

        write_reg(5'd6, 64'hF000_0000);
        load_ir(32'h00C0_0000);
        step();
        pcsrc = c_pcsrc_jr; pcen = 1;
        step();
        pcen = 0;
        load_ir(32'h0800_0010);
        pcsrc = c_pcsrc_jump; pcen = 1;
        step();
        pcen = 0; pcsrc = c_pcsrc_alu;
        #1 check("jump_pc", 64'(bus32.adr), 64'hF000_0040);

        // reset mid-instruction with enables asserted
        pcen = 1; irwrite = 1; rd = 64'hFFFF_FFFF; reset = 1;
        step();
        reset = 0; pcen = 0; irwrite = 0;
        #1 check("midreset_adr", 64'(bus32.adr), 64'h100);
        check("midreset_op", 64'(bus32.op), 64'h0);
        check("midreset_adr64", bus64.adr, 64'h0);

        // 64-bit instance: sign extension of immediates
        load_ir(32'h2000_FFFC);
        alusrca = 0; alusrcb = c_srcb_imm; alucontrol = c_alu_add;
        step();
        iord = 1;
        #1 check("sext64", bus64.adr, 64'hFFFF_FFFF_FFFF_FFFC);
        alusrcb = c_srcb_immsh;
        step();
        check("sext64_sh", bus64.adr, 64'hFFFF_FFFF_FFFF_FFF0);
        iord = 0; alusrcb = c_srcb_b;

        // r20 lies outside a 16-entry file and must not alias r4
        write_reg(5'd4, 64'h8000_0000_0000_0077);
        write_reg(5'd20, 64'h99);
        load_ir(32'h0004_0000);
        step();
        check("r4_64", bus64.writedata, 64'h8000_0000_0000_0077);
        load_ir(32'h0014_0000);
        step();
        check("r20_64", bus64.writedata, 64'h0);

        load_ir(32'h0080_0000);
        step();
        pcsrc = c_pcsrc_jr; pcen = 1;
        step();
        pcen = 0; pcsrc = c_pcsrc_alu;
        #1 check("jr64_pc", bus64.adr, 64'h8000_0000_0000_0077);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
